// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NREAD asynchronous read ports
// and one synchronous write port. A hardware sweep zeroes every entry after
// reset; busy stays high until the sweep finishes, and reads return zero
// while busy is high. Entry 0 can optionally be hardwired to zero.
// Optional build macro: REGFILE_BYPASS_EN adds write-through forwarding from
// an accepted same-cycle write to any read port addressing the same entry.
module regfile_mp #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [AWIDTH-1:0]        wa,
  input  logic [DWIDTH-1:0]        wd,
  input  logic [NREAD*AWIDTH-1:0]  ra,
  output logic [NREAD*DWIDTH-1:0]  rd,
  output logic                     busy,
  output logic                     wr_ack
);

  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic              accept;

  // busy comes straight from the state flop, so it is a registered output
  assign busy = (state_q == CLEAR);

  assign accept = we && !busy && !rst && !((ZERO_REG != 0) && (wa == '0));

  // State register, clear pointer and write acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      wr_ack    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_ack    <= accept;
    end
  end

  // Next-state: sweep clr_ptr through every entry, leave CLEAR after the last
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + AWIDTH'(1);
        if (clr_ptr_q == '1) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Storage: sweep writes zeros while clearing; otherwise accepted writes land
  always_ff @(posedge clk) begin
    if (!rst && (state_q == CLEAR)) begin
      mem[clr_ptr_q] <= '0;
    end else if (accept) begin
      mem[wa] <= wd;
    end
  end

  // Read ports: stored value, optional forwarding, zero-register, busy mask
  always_comb begin : read_ports
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] val;
    rd = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      addr = ra[i*AWIDTH +: AWIDTH];
      val  = mem[addr];
`ifdef REGFILE_BYPASS_EN
      if (accept && (addr == wa)) begin
        val = wd;
      end
`endif
      if ((ZERO_REG != 0) && (addr == '0)) begin
        val = '0;
      end
      if (busy) begin
        val = '0;
      end
      rd[i*DWIDTH +: DWIDTH] = val;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: two regfile_mp instances (ZERO_REG=1 and ZERO_REG=0) share
// one directed stimulus stream. A behavioural model (clear countdown plus a
// plain array per instance) predicts busy, wr_ack and every read port; a
// negedge process compares all outputs each cycle, and the directed sequence
// adds hand-computed literal checks.
module tb_regfile_mp;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd_z, rd_n;
  logic        busy_z, busy_n, ack_z, ack_n;

  int nvec = 0;
  int nerr = 0;

  regfile_mp #(.DWIDTH(32), .AWIDTH(5), .NREAD(2), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(rd_z), .busy(busy_z), .wr_ack(ack_z)
  );

  regfile_mp #(.DWIDTH(32), .AWIDTH(5), .NREAD(2), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(rd_n), .busy(busy_n), .wr_ack(ack_n)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          mvalid = 1'b0;
  bit          mbusy;
  int          mcnt;
  bit          mack_z, mack_n;
  logic [31:0] mz [DEPTH];
  logic [31:0] mn [DEPTH];

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mvalid = 1'b1;
        mbusy  = 1'b1;
        mcnt   = 0;
        mack_z = 1'b0;
        mack_n = 1'b0;
      end else if (mvalid) begin
        if (mbusy) begin
          mack_z = 1'b0;
          mack_n = 1'b0;
          mcnt++;
          if (mcnt == DEPTH) begin
            mbusy = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
              mz[i] = '0;
              mn[i] = '0;
            end
          end
        end else begin
          mack_z = we && (wa != 5'd0);
          mack_n = we;
          if (mack_z) mz[wa] = wd;
          if (mack_n) mn[wa] = wd;
        end
      end
    end
  end

  function automatic logic [31:0] exp_rd(input bit zr, input logic [4:0] a);
    if (mbusy) return 32'h0;
    if (zr && a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && we && (!zr || wa != 5'd0) && a == wa) return wd;
`endif
    return zr ? mz[a] : mn[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        chk("busy_z", {31'd0, busy_z}, {31'd0, mbusy});
        chk("busy_n", {31'd0, busy_n}, {31'd0, mbusy});
        chk("ack_z", {31'd0, ack_z}, {31'd0, mack_z});
        chk("ack_n", {31'd0, ack_n}, {31'd0, mack_n});
        chk("rd_z0", rd_z[31:0],  exp_rd(1'b1, ra[4:0]));
        chk("rd_z1", rd_z[63:32], exp_rd(1'b1, ra[9:5]));
        chk("rd_n0", rd_n[31:0],  exp_rd(1'b0, ra[4:0]));
        chk("rd_n1", rd_n[63:32], exp_rd(1'b0, ra[9:5]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input string name);
    int cycles = 0;
    while (busy_z && cycles < 100) begin
      tick();
      cycles++;
      if (busy_z) chk({name, "_ack_busy"}, {31'd0, ack_z}, 32'd0);
    end
    chk(name, 32'(cycles), 32'd32);
  endtask

  // Read entries on both ports and compare to literal expectations (inst Z)
  task automatic rdchk(input string name, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1);
    tick();
    ra = {a1, a0};
    #2;
    chk({name, "_p0"}, rd_z[31:0], e0);
    chk({name, "_p1"}, rd_z[63:32], e1);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;

    // 1/2. reset two edges, clear sweep with a write attempt held throughout
    tick(); tick();
    rst = 1'b0;
    we = 1'b1; wa = 5'd5; wd = 32'hFFFF_FFFF;
    wait_clear("clear_cycles");
    we = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rdchk("cleared", 5'(i), 5'(i), 32'h0, 32'h0);
      chk("cleared_n", rd_n[31:0], 32'h0);
    end
    rdchk("busy_write_dropped", 5'd5, 5'd5, 32'h0, 32'h0);

    // 3. zero register
    tick();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
    tick();
    we = 1'b0;
    chk("zr_ack_z", {31'd0, ack_z}, 32'd0);
    chk("zr_ack_n", {31'd0, ack_n}, 32'd1);
    ra = '0;
    #2;
    chk("zr_rd_z0", rd_z[31:0], 32'h0);
    chk("zr_rd_z1", rd_z[63:32], 32'h0);
    chk("zr_rd_n0", rd_n[31:0], 32'hFFFF_FFFF);

    // 4. fill 1..31 and read back crosswise
    for (int i = 1; i < DEPTH; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'hDEAD_0000 + 32'(i);
      tick();
      chk("fill_ack", {31'd0, ack_z}, 32'd1);
    end
    we = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rdchk("fill_rd", 5'(i), 5'(31 - i),
            (i == 0) ? 32'h0 : 32'hDEAD_0000 + 32'(i),
            (i == 31) ? 32'h0 : 32'hDEAD_0000 + 32'(31 - i));
    end
    wa = 5'd1; wd = 32'hFEED_FEED;
    rdchk("we_low", 5'd1, 5'd1, 32'hDEAD_0001, 32'hDEAD_0001);
    tick();
    chk("we_low_ack", {31'd0, ack_z}, 32'd0);
    chk("we_low_rd", rd_z[31:0], 32'hDEAD_0001);

    // 5. same-cycle read/write of entry 7
    ra = {5'd0, 5'd7};
    we = 1'b1; wa = 5'd7; wd = 32'h1234_5678;
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("raw_pre", rd_z[31:0], 32'h1234_5678);
`else
    chk("raw_pre", rd_z[31:0], 32'hDEAD_0007);
`endif
    tick();
    we = 1'b0;
    #1;
    chk("raw_post", rd_z[31:0], 32'h1234_5678);

    // 6. reset mid-clear restarts the sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", {31'd0, busy_z}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("restart_busy", {31'd0, busy_z}, 32'd1);
    wait_clear("restart_cycles");
    for (int i = 0; i < DEPTH; i++) begin
      rdchk("recleared", 5'(i), 5'(31 - i), 32'h0, 32'h0);
      chk("recleared_n", rd_n[31:0], 32'h0);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
